key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 119 +++++++++++
 tb/tb_key_conditioner.sv | 132 +++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Two-button conditioner: synchronise, debounce and auto-repeat the up/down keys,
// emitting mutually exclusive one-cycle step pulses.
module key_conditioner #(
    parameter int CW       = 25,
    parameter int DEB_CNT  = 500000,
    parameter int HOLD_CNT = 25000000,
    parameter int REP_CNT  = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic bu,
    input  logic bd,
    output logic xu,
    output logic xd
);

    typedef enum logic [2:0] {IDLE, DEB_P, HOLD, REPEAT, DEB_R} state_t;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CNT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CNT - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CNT - 1);

    logic [1:0] sync1, sync2;   // bit 0 = up, bit 1 = down
    logic [1:0] raise;
    logic [1:0] pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            pulse <= '0;
        end else begin
            sync1 <= {bd, bu};
            sync2 <= sync1;
            // A channel's pulse is dropped while the other key is down.
            pulse <= ena ? {raise[1] & ~sync2[0], raise[0] & ~sync2[1]} : '0;
        end
    end

    assign xu = pulse[0];
    assign xd = pulse[1];

    for (genvar g = 0; g < 2; g++) begin : g_chan
        state_t        state, state_n;
        logic [CW-1:0] cnt, cnt_n;
        logic          s, hit;

        assign s = sync2[g];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (ena) begin
                state <= state_n;
                cnt   <= cnt_n;
            end
        end

        always_comb begin
            state_n = state;
            cnt_n   = cnt + 1'b1;
            hit     = 1'b0;
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (s) state_n = DEB_P;
                end
                DEB_P: begin
                    if (!s) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                        hit     = 1'b1;
                    end
                end
                HOLD: begin
                    if (!s) begin
                        state_n = DEB_R;
                        cnt_n   = '0;
                    end else if (cnt == HOLD_LAST) begin
                        state_n = REPEAT;
                        cnt_n   = '0;
                        hit     = 1'b1;
                    end
                end
                REPEAT: begin
                    if (!s) begin
                        state_n = DEB_R;
                        cnt_n   = '0;
                    end else if (cnt == REP_LAST) begin
                        cnt_n = '0;
                        hit   = 1'b1;
                    end
                end
                DEB_R: begin
                    // A re-press while releasing resumes holding without a new step.
                    if (s) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        assign raise[g] = hit;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short timing parameters; segments of
// constant inputs list the relative edge at which each pulse is expected.
module tb_key_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b1;
    logic bu  = 1'b0;
    logic bd  = 1'b0;
    logic xu, xd;

    int checks = 0;
    int errors = 0;

    key_conditioner #(
        .CW(8),
        .DEB_CNT(4),
        .HOLD_CNT(10),
        .REP_CNT(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .bu(bu),
        .bd(bd),
        .xu(xu),
        .xd(xd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;   // reset before this segment
        bit bu;
        bit bd;
        bit ena;
        int n;     // edges to apply
        int pu;    // relative edge with xu=1 (0 = none)
        int pd;    // relative edge with xd=1 (0 = none)
    } seg_t;

    seg_t tab [22];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bu  = 1'b0;
        bd  = 1'b0;
        ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_xu", xu, 1'b0);
        check("reset_xd", xd, 1'b0);
        rst = 1'b0;
    endtask

    task automatic run_seg(input int idx, input seg_t s);
        if (s.rst) do_reset();
        bu  = s.bu;
        bd  = s.bd;
        ena = s.ena;
        for (int e = 1; e <= s.n; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("seg%0d_e%0d_xu", idx, e), xu, (e == s.pu));
            check($sformatf("seg%0d_e%0d_xd", idx, e), xd, (e == s.pd));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        seg_t s;
        // clean press: pulses at edges 7, 17, 22, 27
        tab[0]  = '{1, 1, 0, 1, 7, 7, 0};
        tab[1]  = '{0, 1, 0, 1, 10, 10, 0};
        tab[2]  = '{0, 1, 0, 1, 5, 5, 0};
        tab[3]  = '{0, 1, 0, 1, 5, 5, 0};
        // bounce: 3 high, 2 low, then held -> pulse 7 edges after final rise
        tab[4]  = '{1, 1, 0, 1, 3, 0, 0};
        tab[5]  = '{0, 0, 0, 1, 2, 0, 0};
        tab[6]  = '{0, 1, 0, 1, 7, 7, 0};
        tab[7]  = '{0, 1, 0, 1, 10, 10, 0};
        // release and re-press on down: no pulse on re-press, HOLD expires at edge 23
        tab[8]  = '{1, 0, 1, 1, 8, 0, 7};
        tab[9]  = '{0, 0, 0, 1, 2, 0, 0};
        tab[10] = '{0, 0, 1, 1, 13, 0, 13};
        tab[11] = '{0, 0, 1, 1, 5, 0, 5};
        // both keys together
        tab[12] = '{1, 1, 1, 1, 40, 0, 0};
        // short glitch on down
        tab[13] = '{1, 0, 1, 1, 3, 0, 0};
        tab[14] = '{0, 0, 0, 1, 10, 0, 0};
        // enable freeze during REPEAT: pulse at 22, freeze edges 24..43, next pulse at 47
        tab[15] = '{1, 1, 0, 1, 7, 7, 0};
        tab[16] = '{0, 1, 0, 1, 10, 10, 0};
        tab[17] = '{0, 1, 0, 1, 5, 5, 0};
        tab[18] = '{0, 1, 0, 1, 1, 0, 0};
        tab[19] = '{0, 1, 0, 0, 20, 0, 0};
        tab[20] = '{0, 1, 0, 1, 4, 4, 0};
        tab[21] = '{0, 1, 0, 1, 5, 5, 0};

        for (int i = 0; i < 22; i++) run_seg(i, tab[i]);

        // asynchronous reset while xu is high, between clock edges
        check("pre_rst_xu", xu, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_xu", xu, 1'b0);
        check("async_rst_xd", xd, 1'b0);
        #1 rst = 1'b0;
        s = '{0, 1, 0, 1, 7, 7, 0};
        run_seg(100, s);
        s = '{0, 1, 0, 1, 10, 10, 0};
        run_seg(101, s);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
